ram_master_ctrl: RTL and testbench

RAM_MASTER_CTRL -- requirements
Module: ram_master_ctrl

---
 rtl/ram_master_ctrl_if.sv | 37 +++
 rtl/ram_master_ctrl.sv | 99 +++++++++
 tb/tb_ram_master_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_ctrl_if.sv
// Command, write/read stream and RAM-side signals of the burst RAM controller.
interface ram_master_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [ADDR_WIDTH-1:0] cmd_len;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  done;
   logic                  busy;
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_din;
   logic [DATA_WIDTH-1:0] ram_dout;

   // Controller side: accepts commands and streams, drives the RAM.
   modport master (
      input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, ram_dout,
      output cmd_ready, wr_ready, rd_valid, rd_data, done, busy,
             ram_en, ram_we, ram_addr, ram_din
   );

   // Environment side: issues commands, supplies write data, models the RAM.
   modport slave (
      output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, ram_dout,
      input  cmd_ready, wr_ready, rd_valid, rd_data, done, busy,
             ram_en, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_master_ctrl.sv
// Burst read/write controller in front of a synchronous single-port RAM.
module ram_master_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic              clk,
   input  logic              rst,
   ram_master_ctrl_if.master bus_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] beat_q;
   logic                  done_q;
   logic                  rd_valid_q;

   logic                  ram_en_c;
   logic                  ram_we_c;

   // Burst sequencing: address/beat counters, done pulse and read-valid pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beat_q     <= '0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus_if.cmd_valid) begin
                  addr_q  <= bus_if.cmd_addr;
                  beat_q  <= bus_if.cmd_len;
                  state_q <= bus_if.cmd_we ? WRITE : READ;
               end
            end
            WRITE: begin
               if (bus_if.wr_valid) begin
                  addr_q <= addr_q + ADDR_WIDTH'(1);
                  beat_q <= beat_q - ADDR_WIDTH'(1);
                  if (beat_q == '0) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               rd_valid_q <= 1'b1;
               addr_q     <= addr_q + ADDR_WIDTH'(1);
               beat_q     <= beat_q - ADDR_WIDTH'(1);
               if (beat_q == '0) begin
                  state_q <= DRAIN;
                  done_q  <= 1'b1;
               end
            end
            DRAIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // RAM strobes: write beats follow wr_valid, reads issue every READ cycle.
   always_comb begin
      ram_en_c = 1'b0;
      ram_we_c = 1'b0;
      if (state_q == WRITE) begin
         ram_en_c = bus_if.wr_valid;
         ram_we_c = bus_if.wr_valid;
      end else if (state_q == READ) begin
         ram_en_c = 1'b1;
      end
   end

   assign bus_if.cmd_ready = (state_q == IDLE);
   assign bus_if.busy      = (state_q != IDLE);
   assign bus_if.wr_ready  = (state_q == WRITE);
   assign bus_if.ram_en    = ram_en_c;
   assign bus_if.ram_we    = ram_we_c;
   assign bus_if.ram_addr  = addr_q;
   assign bus_if.ram_din   = bus_if.wr_data;
   assign bus_if.done      = done_q;
   assign bus_if.rd_valid  = rd_valid_q;
   // RAM output is only meaningful one cycle after a read issue; mask it otherwise.
   assign bus_if.rd_data   = rd_valid_q ? bus_if.ram_dout : '0;

endmodule

// File: tb/tb_ram_master_ctrl.sv
// Bench for ram_master_ctrl: RAM model, burst vector table, scoreboarded data.
module tb_ram_master_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   ram_master_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_master_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Synchronous RAM model attached to the controller.
   logic [DW-1:0] mem [8];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
         else            bus.ram_dout      <= mem[bus.ram_addr];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard state
   logic [DW-1:0] ref_mem [8];
   logic [15:0]   wr_q [$];
   logic [DW-1:0] rd_q [$];
   int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   int last_wr_cyc = 0, last_rd_cyc = 0, first_rd_cyc = 0, done_cyc = 0;
   logic [DW-1:0] first_rd_data;
   bit rd_seen = 0;
   int ready_viol = 0, idle_viol = 0;

   // Monitor: compare RAM writes and read data against queued expectations.
   always @(negedge clk) begin
      if (bus.ram_en && bus.ram_we) begin
         wr_cnt++;
         last_wr_cyc = cyc;
         if (wr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.ram_addr, bus.ram_din);
         end else begin
            logic [15:0] e;
            e = wr_q.pop_front();
            check("wr_addr", 32'(bus.ram_addr), 32'(e[15:8]));
            check("wr_data", 32'(bus.ram_din), 32'(e[7:0]));
         end
      end
      if (bus.rd_valid) begin
         if (!rd_seen) begin
            rd_seen       = 1;
            first_rd_cyc  = cyc;
            first_rd_data = bus.rd_data;
         end
         rd_cnt++;
         last_rd_cyc = cyc;
         if (rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rd_valid: data %0h, none expected", bus.rd_data);
         end else begin
            check("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
         end
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy && bus.cmd_ready) ready_viol++;
      if (!bus.busy && (bus.ram_en || bus.wr_ready)) idle_viol++;
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [AW-1:0] len;
      logic [DW-1:0] base;
      logic [7:0]    vpat;
      int            exp_beats;
      logic [DW-1:0] exp_first;
   } vec_t;

   task automatic push_expect(input logic we, input logic [AW-1:0] addr,
                              input logic [AW-1:0] len, input logic [DW-1:0] base);
      for (int i = 0; i <= int'(len); i++) begin
         logic [AW-1:0] a;
         a = addr + AW'(i);
         if (we) begin
            wr_q.push_back({8'(a), base + DW'(i)});
            ref_mem[a] = base + DW'(i);
         end else begin
            rd_q.push_back(ref_mem[a]);
         end
      end
   endtask

   task automatic wait_idle(output int idle_cyc);
      int guard = 0;
      while (bus.busy && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (bus.busy) begin
         n_checks++; n_fail++;
         $display("FAIL idle_timeout: busy still %0b after %0d cycles", bus.busy, guard);
      end
      idle_cyc = cyc;
   endtask

   task automatic run_burst(input vec_t v, input int idx);
      int d0, w0, r0, beat, k, idle_cyc;
      string tag;
      tag = $sformatf("v%0d", idx);
      push_expect(v.we, v.addr, v.len, v.base);
      d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt; rd_seen = 0;
      @(posedge clk); #1;
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = v.we;
      bus.cmd_addr  = v.addr;
      bus.cmd_len   = v.len;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (v.we) begin
         beat = 0; k = 0;
         while (beat <= int'(v.len) && k < 64) begin
            bus.wr_valid = v.vpat[k % 8];
            bus.wr_data  = v.base + DW'(beat);
            check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
            @(posedge clk);
            if (bus.wr_valid) beat++;
            #1;
            k++;
         end
         bus.wr_valid = 1'b0;
      end
      wait_idle(idle_cyc);
      @(negedge clk); @(negedge clk); #1;
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      if (v.we) begin
         check({tag, "_write_beats"}, 32'(wr_cnt - w0), 32'(v.exp_beats));
         check({tag, "_done_after_last_write"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
         check({tag, "_idle_at_done"}, 32'(idle_cyc), 32'(done_cyc));
      end else begin
         check({tag, "_read_beats"}, 32'(rd_cnt - r0), 32'(v.exp_beats));
         check({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
         check({tag, "_first_data"}, 32'(first_rd_data), 32'(v.exp_first));
         check({tag, "_consecutive"}, 32'(last_rd_cyc - first_rd_cyc), 32'(v.exp_beats - 1));
         check({tag, "_done_with_last_rd"}, 32'(done_cyc), 32'(last_rd_cyc));
         check({tag, "_idle_after_drain"}, 32'(idle_cyc), 32'(done_cyc + 1));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      check({tag, "_busy"},      32'(bus.busy),      32'd0);
      check({tag, "_done"},      32'(bus.done),      32'd0);
      check({tag, "_rd_valid"},  32'(bus.rd_valid),  32'd0);
      check({tag, "_rd_data"},   32'(bus.rd_data),   32'd0);
      check({tag, "_ram_en"},    32'(bus.ram_en),    32'd0);
      check({tag, "_ram_we"},    32'(bus.ram_we),    32'd0);
      check({tag, "_wr_ready"},  32'(bus.wr_ready),  32'd0);
   endtask

   initial begin
      vec_t vecs [7];
      vec_t v;
      int d0, r0, w0, ready_cyc, idle_cyc, g;

      vecs[0] = '{1'b1, 3'd2, 3'd3, 8'hA0, 8'hFF, 4, 8'h00};
      vecs[1] = '{1'b0, 3'd2, 3'd3, 8'h00, 8'h00, 4, 8'hA0};
      vecs[2] = '{1'b1, 3'd6, 3'd3, 8'hB0, 8'h35, 4, 8'h00};
      vecs[3] = '{1'b0, 3'd6, 3'd3, 8'h00, 8'h00, 4, 8'hB0};
      vecs[4] = '{1'b0, 3'd0, 3'd7, 8'h00, 8'h00, 8, 8'hB2};
      vecs[5] = '{1'b1, 3'd7, 3'd0, 8'hC0, 8'hFF, 1, 8'h00};
      vecs[6] = '{1'b0, 3'd7, 3'd1, 8'h00, 8'h00, 2, 8'hC0};

      for (int i = 0; i < 8; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      bus.ram_dout  = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_we    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      rst = 1'b1;
      #2;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

      // Reset during the third beat of a 6-beat read.
      push_expect(1'b0, 3'd0, 3'd5, 8'h00);
      d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_len = 3'd5;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      rd_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("midrst_rd_beats", 32'(rd_cnt - r0), 32'd1);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      check("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      v = '{1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1, 8'hB2};
      run_burst(v, 7);

      // Second command held on cmd_valid while the first burst runs.
      push_expect(1'b0, 3'd0, 3'd3, 8'h00);
      push_expect(1'b0, 3'd4, 3'd0, 8'h00);
      d0 = done_cnt; r0 = rd_cnt;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 3'd0; bus.cmd_len = 3'd3;
      @(posedge clk); #1;
      bus.cmd_addr = 3'd4; bus.cmd_len = 3'd0;
      g = 0;
      while (!bus.cmd_ready && g < 20) begin
         @(posedge clk); #1;
         g++;
      end
      ready_cyc = cyc;
      check("hold_ready_seen", 32'(bus.cmd_ready), 32'd1);
      check("hold_first_done", 32'(done_cnt - d0), 32'd1);
      check("hold_first_beats", 32'(rd_cnt - r0), 32'd4);
      check("hold_ready_after_drain", 32'(ready_cyc), 32'(done_cyc + 1));
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check("hold_second_accepted", 32'(bus.busy), 32'd1);
      wait_idle(idle_cyc);
      @(negedge clk); @(negedge clk); #1;
      check("hold_total_done", 32'(done_cnt - d0), 32'd2);
      check("hold_total_beats", 32'(rd_cnt - r0), 32'd5);

      check("ready_while_busy", 32'(ready_viol), 32'd0);
      check("ram_active_when_idle", 32'(idle_viol), 32'd0);
      check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
